// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB register completer.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned WAIT_W     = 4;

endpackage

// File: rtl/apb_reg_slave_regfile.sv
// DEPTH x DATA_W register storage: one synchronous write port, one
// combinational read port, asynchronous clear.
module apb_reg_slave_regfile #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Guard against indices past DEPTH when DEPTH is not a power of two.
    always_comb begin
        rdata_o = '0;
        if (32'(raddr_i) < DEPTH) begin
            rdata_o = mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/apb_reg_slave.sv
// APB completer: register file with wait states, PSLVERR on out-of-range
// addresses, and write/error statistics. All outputs are registered.
module apb_reg_slave
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  err_count
);

    localparam int unsigned      IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES);

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [WAIT_W-1:0]   wait_q;
    logic [DATA_W-1:0]   prdata_q;
    logic                pready_q;
    logic                pslverr_q;
    logic [CNT_W-1:0]    wr_cnt_q;
    logic [CNT_W-1:0]    err_cnt_q;

    logic                addr_ok;
    logic                setup;
    logic                complete;
    logic                reg_we;
    logic [IDX_W-1:0]    idx;
    logic [DATA_W-1:0]   rf_rdata;

    always_comb begin
        addr_ok  = 32'(addr_q) < DEPTH;
        idx      = addr_q[IDX_W-1:0];
        setup    = PSEL && !PENABLE && (state_q == IDLE || state_q == DONE);
        complete = (state_q == WAIT) && PSEL && PENABLE && (wait_q == WAIT_LAST);
        reg_we   = complete && write_q && addr_ok;
    end

    apb_reg_slave_regfile #(
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk_i   (clk),
        .rst_i   (reset),
        .we_i    (reg_we),
        .waddr_i (idx),
        .wdata_i (wdata_q),
        .raddr_i (idx),
        .rdata_o (rf_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            wait_q    <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            // Setup capture is shared by IDLE and the back-to-back path in DONE.
            if (setup) begin
                addr_q  <= PADDR;
                write_q <= PWRITE;
                wdata_q <= PWDATA;
                wait_q  <= '0;
            end
            case (state_q)
                IDLE: begin
                    if (setup) state_q <= WAIT;
                end
                WAIT: begin
                    if (!PSEL) begin
                        state_q <= IDLE;
                    end else if (PENABLE) begin
                        if (wait_q != WAIT_LAST) begin
                            wait_q <= wait_q + 1'b1;
                        end else begin
                            pready_q <= 1'b1;
                            state_q  <= DONE;
                            if (!addr_ok) begin
                                pslverr_q <= 1'b1;
                                prdata_q  <= '0;
                                if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
                            end else if (write_q) begin
                                prdata_q <= '0;
                                wr_cnt_q <= wr_cnt_q + 1'b1;
                            end else begin
                                prdata_q <= rf_rdata;
                            end
                        end
                    end
                end
                DONE: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    prdata_q  <= '0;
                    state_q   <= setup ? WAIT : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign PRDATA    = prdata_q;
    assign PREADY    = pready_q;
    assign PSLVERR   = pslverr_q;
    assign wr_count  = wr_cnt_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Scoreboard bench for apb_reg_slave: the driver queues expected responses,
// the monitor checks each PREADY pulse and the idle-cycle output values.
module tb_apb_reg_slave;

    localparam int unsigned WAIT_C = 3;
    localparam int unsigned LIMIT  = WAIT_C + 6;

    logic       clk;
    logic       reset;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;
    logic [7:0] wr_count;
    logic [7:0] err_count;

    apb_reg_slave #(
        .ADDR_W      (8),
        .DATA_W      (8),
        .DEPTH       (16),
        .WAIT_CYCLES (WAIT_C)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .wr_count  (wr_count),
        .err_count (err_count)
    );

    typedef struct {
        int unsigned setup_cyc;
        logic [7:0]  rdata;
        logic        err;
        logic [7:0]  wr;
        logic [7:0]  errc;
    } exp_t;

    typedef struct {
        string       tag;
        int unsigned act;
        int unsigned exp;
    } chk_t;

    exp_t        sb_q[$];
    chk_t        chk_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc   = 0;
    logic        prev_ready = 1'b0;

    logic [7:0]  mem_m [16];
    logic [7:0]  wr_m;
    logic [7:0]  err_m;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string tag, int unsigned act, int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endfunction

    // Monitor: sole owner of the comparison counters.
    always @(negedge clk) begin
        exp_t e;
        chk_t c;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            check(c.tag, c.act, c.exp);
        end
        if (reset) begin
            prev_ready = 1'b0;
        end else begin
            if (PREADY) begin
                check("ready_single_cycle", 32'(prev_ready), 0);
                check("ready_expected", (sb_q.size() > 0) ? 1 : 0, 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("latency", cyc - e.setup_cyc, WAIT_C + 1);
                    check("prdata", 32'(PRDATA), 32'(e.rdata));
                    check("pslverr", 32'(PSLVERR), 32'(e.err));
                    check("wr_count", 32'(wr_count), 32'(e.wr));
                    check("err_count", 32'(err_count), 32'(e.errc));
                end
            end else begin
                check("idle_outputs_zero", 32'({PSLVERR, PRDATA}), 0);
                if (sb_q.size() > 0 && (cyc - sb_q[0].setup_cyc) > LIMIT) begin
                    check("ready_timeout", cyc - sb_q[0].setup_cyc, LIMIT);
                    void'(sb_q.pop_front());
                end
            end
            prev_ready = PREADY;
        end
    end

    task automatic push_chk(input string tag, input int unsigned act, input int unsigned exp);
        chk_t c;
        c.tag = tag;
        c.act = act;
        c.exp = exp;
        chk_q.push_back(c);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
        wr_m  = 8'h00;
        err_m = 8'h00;
    endtask

    // mode: 0 normal, 1 back-to-back (return at PREADY), 2 abort, 3 reset mid-transfer
    task automatic xfer(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                        input int mode);
        exp_t e;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = data;
        @(posedge clk);
        #1;
        PENABLE = 1'b1;
        PADDR   = ~addr;
        PWDATA  = ~data;
        if (mode == 2) begin
            @(posedge clk);
            #1;
            PSEL    = 1'b0;
            PENABLE = 1'b0;
            @(posedge clk);
            #1;
            return;
        end
        if (mode == 3) begin
            @(posedge clk);
            @(negedge clk);
            #2 reset = 1'b1;
            #1;
            push_chk("reset_pready", 32'(PREADY), 0);
            push_chk("reset_wr_count", 32'(wr_count), 0);
            push_chk("reset_err_count", 32'(err_count), 0);
            model_clear();
            @(negedge clk);
            #2 reset = 1'b0;
            PSEL    = 1'b0;
            PENABLE = 1'b0;
            @(posedge clk);
            #1;
            return;
        end
        e.setup_cyc = cyc;
        e.rdata     = 8'h00;
        e.err       = 1'b0;
        if (addr >= 8'd16) begin
            e.err = 1'b1;
            if (err_m != 8'hFF) err_m = err_m + 8'd1;
        end else if (wr) begin
            mem_m[addr[3:0]] = data;
            wr_m = wr_m + 8'd1;
        end else begin
            e.rdata = mem_m[addr[3:0]];
        end
        e.wr   = wr_m;
        e.errc = err_m;
        sb_q.push_back(e);
        for (int i = 0; i < int'(LIMIT) + 2; i++) begin
            @(negedge clk);
            if (PREADY) break;
        end
        if (mode == 1) return;
        @(posedge clk);
        #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    initial begin
        reset   = 1'b1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = 8'h00;
        PWDATA  = 8'h00;
        model_clear();
        repeat (2) @(negedge clk);
        push_chk("reset_prdata", 32'(PRDATA), 0);
        push_chk("reset_pready", 32'(PREADY), 0);
        push_chk("reset_pslverr", 32'(PSLVERR), 0);
        push_chk("reset_wr_count", 32'(wr_count), 0);
        push_chk("reset_err_count", 32'(err_count), 0);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;

        xfer(1'b1, 8'd3, 8'hA5, 0);
        xfer(1'b0, 8'd3, 8'h00, 0);
        xfer(1'b1, 8'd15, 8'h3C, 0);
        xfer(1'b0, 8'd15, 8'h00, 0);
        xfer(1'b0, 8'd0, 8'h00, 0);

        xfer(1'b1, 8'h20, 8'h55, 0);
        xfer(1'b0, 8'd3, 8'h00, 0);
        xfer(1'b0, 8'd16, 8'h00, 0);
        xfer(1'b0, 8'hFF, 8'h00, 0);

        xfer(1'b1, 8'd5, 8'h99, 2);
        xfer(1'b0, 8'd5, 8'h00, 0);
        xfer(1'b1, 8'd5, 8'h42, 0);
        xfer(1'b0, 8'd5, 8'h00, 0);

        xfer(1'b1, 8'd2, 8'h77, 3);
        xfer(1'b0, 8'd2, 8'h00, 0);
        xfer(1'b0, 8'd3, 8'h00, 0);

        for (int i = 0; i < 256; i++) begin
            xfer(1'b1, 8'(i % 16), 8'(i), 1);
        end
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        @(posedge clk);
        #1;
        xfer(1'b0, 8'd15, 8'h00, 0);
        xfer(1'b0, 8'd7, 8'h00, 0);

        for (int i = 0; i < 256; i++) begin
            xfer(1'b0, 8'h80, 8'h00, 0);
        end
        xfer(1'b1, 8'd1, 8'h11, 0);
        xfer(1'b0, 8'd1, 8'h00, 0);

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
        push_chk("scoreboard_drained", 32'(sb_q.size()), 0);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
